// File: rtl/vector_multicycle_alu_if.sv
// Purpose: operand/result handshake bundle between the execute pipeline and the vector ALU.
// Latency: none; wires only.
// Backpressure: startValid/startReady on operands, resultValid/resultReady on result, busy as stall.
//
// Ports (signals):
//   startValid/startReady, aluControl, saturate, useScalar  - operation request handshake
//   vectorOperand1/2, scalarOperand                          - operands, element i at index i
//   resultValid/resultReady, result, zeroMask                - result handshake
//   busy                                                     - pipeline stall request
// Modports: master = pipeline side, slave = ALU side.
interface vector_multicycle_alu_if #(
    parameter int VECTOR_DATA_WIDTH = 8,
    parameter int VECTOR_SIZE       = 6,
    parameter int ALU_CONTROL_WIDTH = 3
);
    logic                                            startValid;
    logic                                            startReady;
    logic [ALU_CONTROL_WIDTH-1:0]                    aluControl;
    logic                                            saturate;
    logic                                            useScalar;
    logic [VECTOR_SIZE-1:0][VECTOR_DATA_WIDTH-1:0]   vectorOperand1;
    logic [VECTOR_SIZE-1:0][VECTOR_DATA_WIDTH-1:0]   vectorOperand2;
    logic [VECTOR_DATA_WIDTH-1:0]                    scalarOperand;
    logic                                            resultValid;
    logic                                            resultReady;
    logic [VECTOR_SIZE-1:0][VECTOR_DATA_WIDTH-1:0]   result;
    logic [VECTOR_SIZE-1:0]                          zeroMask;
    logic                                            busy;

    modport master (
        output startValid, aluControl, saturate, useScalar,
               vectorOperand1, vectorOperand2, scalarOperand, resultReady,
        input  startReady, resultValid, result, zeroMask, busy
    );

    modport slave (
        input  startValid, aluControl, saturate, useScalar,
               vectorOperand1, vectorOperand2, scalarOperand, resultReady,
        output startReady, resultValid, result, zeroMask, busy
    );
endinterface

// File: rtl/vector_multicycle_alu.sv
// Purpose: multi-cycle vector ALU, LANES element ALUs swept over the vector in PASSES passes.
// Latency: accept at edge T -> resultValid after edge T+PASSES, PASSES = ceil(VECTOR_SIZE/LANES).
// Backpressure: result held in DONE until resultReady; new op accepted in IDLE or on DONE handshake.
//
// Ports:
//   clock - rising-edge clock
//   reset - synchronous, active-low; clears state, pass counter, result, zeroMask, resultValid
//   bus   - vector_multicycle_alu_if.slave (request/result handshakes, busy stall)
module vector_multicycle_alu #(
    parameter int VECTOR_DATA_WIDTH = 8,
    parameter int VECTOR_SIZE       = 6,
    parameter int LANES             = 2,
    parameter int ALU_CONTROL_WIDTH = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    vector_multicycle_alu_if.slave   bus
);
    localparam int W         = VECTOR_DATA_WIDTH;
    localparam int PASSES    = (VECTOR_SIZE + LANES - 1) / LANES;
    localparam int PW        = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int SHW       = (W > 1) ? $clog2(W) : 1;
    localparam int VEC_BITS  = VECTOR_SIZE * W;
    localparam int GRID_BITS = PASSES * LANES * W;
    localparam int ZGRID     = PASSES * LANES;

    localparam logic [PW-1:0] LAST_PASS = PW'(PASSES - 1);

    localparam logic [ALU_CONTROL_WIDTH-1:0] OP_ADD = ALU_CONTROL_WIDTH'(0);
    localparam logic [ALU_CONTROL_WIDTH-1:0] OP_SUB = ALU_CONTROL_WIDTH'(1);
    localparam logic [ALU_CONTROL_WIDTH-1:0] OP_AND = ALU_CONTROL_WIDTH'(2);
    localparam logic [ALU_CONTROL_WIDTH-1:0] OP_OR  = ALU_CONTROL_WIDTH'(3);
    localparam logic [ALU_CONTROL_WIDTH-1:0] OP_XOR = ALU_CONTROL_WIDTH'(4);
    localparam logic [ALU_CONTROL_WIDTH-1:0] OP_SHL = ALU_CONTROL_WIDTH'(5);
    localparam logic [ALU_CONTROL_WIDTH-1:0] OP_MUL = ALU_CONTROL_WIDTH'(6);
    localparam logic [ALU_CONTROL_WIDTH-1:0] OP_PSB = ALU_CONTROL_WIDTH'(7);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef logic [W-1:0]                          elem_t;
    typedef logic [VECTOR_SIZE-1:0][W-1:0]         vec_t;
    typedef logic [LANES-1:0][W-1:0]               lanes_t;
    // The vector viewed as PASSES rows of LANES elements; the last row is
    // zero-padded when LANES does not divide VECTOR_SIZE, so padding lanes
    // compute on zeros and their results are dropped on the way back.
    typedef logic [PASSES-1:0][LANES-1:0][W-1:0]   grid_t;
    typedef logic [PASSES-1:0][LANES-1:0]          zgrid_t;

    state_t                       state_q, state_d;
    logic [PW-1:0]                pass_q, pass_d;
    logic [ALU_CONTROL_WIDTH-1:0] ctrl_q, ctrl_d;
    logic                         sat_q, sat_d;
    vec_t                         opa_q, opa_d;
    vec_t                         opb_q, opb_d;
    vec_t                         result_q, result_d;
    logic [VECTOR_SIZE-1:0]       zmask_q, zmask_d;
    logic                         valid_q, valid_d;

    logic   start_ready;
    logic   accept;
    grid_t  opa_grid, opb_grid, res_grid;
    zgrid_t zm_grid;
    lanes_t lane_a, lane_b, lane_res;
    logic [LANES-1:0] lane_zero;

    function automatic elem_t lane_alu(input logic [ALU_CONTROL_WIDTH-1:0] op,
                                       input logic sat, input elem_t a, input elem_t b);
        logic [W:0] wide;
        elem_t      r;
        wide = '0;
        r    = '0;
        case (op)
            OP_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                r    = (sat && wide[W]) ? '1 : wide[W-1:0];
            end
            OP_SUB: begin
                // bit W of the extended difference is the borrow
                wide = {1'b0, a} - {1'b0, b};
                r    = (sat && wide[W]) ? '0 : wide[W-1:0];
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SHL:  r = a << b[SHW-1:0];
            OP_MUL:  r = a * b;
            OP_PSB:  r = b;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign start_ready = (state_q == IDLE) || ((state_q == DONE) && bus.resultReady);
    assign accept      = bus.startValid && start_ready;

    // Lane operand select: the current pass picks one row of the grid.
    always_comb begin
        opa_grid = GRID_BITS'(opa_q);
        opb_grid = GRID_BITS'(opb_q);
        lane_a   = opa_grid[pass_q];
        lane_b   = opb_grid[pass_q];
        for (int l = 0; l < LANES; l++) begin
            lane_res[l]  = lane_alu(ctrl_q, sat_q, lane_a[l], lane_b[l]);
            lane_zero[l] = (lane_res[l] == '0);
        end
    end

    always_comb begin
        state_d  = state_q;
        pass_d   = pass_q;
        ctrl_d   = ctrl_q;
        sat_d    = sat_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        zmask_d  = zmask_q;
        valid_d  = valid_q;
        res_grid = GRID_BITS'(result_q);
        zm_grid  = ZGRID'(zmask_q);

        case (state_q)
            IDLE: ;
            RUN: begin
                res_grid[pass_q] = lane_res;
                zm_grid[pass_q]  = lane_zero;
                // Truncating back to the vector discards padding lanes.
                result_d = VEC_BITS'(res_grid);
                zmask_d  = VECTOR_SIZE'(zm_grid);
                if (pass_q == LAST_PASS) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                end else begin
                    pass_d = pass_q + PW'(1);
                end
            end
            DONE: begin
                if (bus.resultReady) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        // Accept is only possible from IDLE or a DONE handshake, so it may
        // override the next state chosen above (back-to-back without a bubble).
        if (accept) begin
            ctrl_d  = bus.aluControl;
            sat_d   = bus.saturate;
            opa_d   = bus.vectorOperand1;
            opb_d   = bus.useScalar ? {VECTOR_SIZE{bus.scalarOperand}} : bus.vectorOperand2;
            pass_d  = '0;
            state_d = RUN;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            pass_q   <= '0;
            ctrl_q   <= '0;
            sat_q    <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            zmask_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pass_q   <= pass_d;
            ctrl_q   <= ctrl_d;
            sat_q    <= sat_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            zmask_q  <= zmask_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.startReady  = start_ready;
    assign bus.resultValid = valid_q;
    assign bus.result      = result_q;
    assign bus.zeroMask    = zmask_q;
    assign bus.busy        = (state_q == RUN) || ((state_q == DONE) && !bus.resultReady);

endmodule

// File: doc/vector_multicycle_alu.md
Name: vector_multicycle_alu

Overview:
Multi-cycle vector ALU for the execute stage. It processes a VECTOR_SIZE-element operation over ceil(VECTOR_SIZE/LANES) passes, using LANES parallel element ALUs. This generalises the single-cycle vector path to configurable element width, lane count and wrap/saturate mode. It talks to the pipeline through a valid/ready handshake on both operands and result; busy drives the pipeline stall.

Parameters:
VECTOR_DATA_WIDTH, 8, bits per element
VECTOR_SIZE, 6, elements per vector
LANES, 2, element ALUs working in parallel (1..VECTOR_SIZE)
ALU_CONTROL_WIDTH, 3, width of operation select

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
startValid  input  1  operands and control valid
startReady  output  1  block can accept an operation this cycle
aluControl  input  ALU_CONTROL_WIDTH  operation select
saturate  input  1  1 = unsigned saturating add/sub, 0 = wrap
useScalar  input  1  1 = broadcast scalarOperand as operand 2
vectorOperand1  input  VECTOR_SIZE x VECTOR_DATA_WIDTH  operand 1, element i at index i
vectorOperand2  input  VECTOR_SIZE x VECTOR_DATA_WIDTH  operand 2
scalarOperand  input  VECTOR_DATA_WIDTH  broadcast operand
resultValid  output  1  result holds a completed operation
resultReady  input  1  consumer takes the result
result  output  VECTOR_SIZE x VECTOR_DATA_WIDTH  result vector
zeroMask  output  VECTOR_SIZE  bit i = 1 when result[i] == 0
busy  output  1  operation in progress; pipeline stall request

Behaviour:
- PASSES = ceil(VECTOR_SIZE/LANES).
- Pass counter width = max(1, clog2(PASSES)).
- FSM states: IDLE, RUN, DONE.
- Reset (reset==0 at clock edge), from any state including mid-RUN:
  - state goes to IDLE; pass counter, result and zeroMask go to 0; resultValid goes to 0.
  - Any in-flight operation is discarded.
- startReady = (state==IDLE) | (state==DONE & resultReady). This is combinational.
- Accept occurs when startValid & startReady. On accept:
  - capture aluControl, saturate, vectorOperand1, and operand 2 (the scalarOperand broadcast if useScalar, else vectorOperand2) into internal registers;
  - clear the pass counter;
  - go to RUN.
- Inputs are ignored after capture.
- RUN, pass p:
  - lane l computes element e = p*LANES + l when e < VECTOR_SIZE; out-of-range lanes write nothing;
  - result[e] and zeroMask[e] update at the clock edge.
  - On the last pass (p == PASSES-1) go to DONE; otherwise p increments.
- Latency: accept at edge T gives resultValid=1 after edge T+PASSES. With the defaults this is 3 cycles; with LANES==VECTOR_SIZE it is 1.
- DONE:
  - resultValid=1; result and zeroMask are held stable until handshake.
  - On resultReady without an accept, go to IDLE. resultValid drops, and result holds its last value.
  - On resultReady with startValid in the same cycle, accept the new operation and go directly to RUN (back-to-back, no bubble).
- busy = (state==RUN) | (state==DONE & ~resultReady).
- Operations, per element a, b (unsigned, VECTOR_DATA_WIDTH bits):
  - 000 add: wrap mod 2^W; if saturate, clamp to 2^W-1 on carry.
  - 001 sub: a-b wrap; if saturate, clamp to 0 on borrow.
  - 010 and.
  - 011 or.
  - 100 xor.
  - 101 shl: a << b[clog2(W)-1:0], zero fill.
  - 110 mul: low W bits of a*b.
  - 111 pass b.
- saturate affects only 000 and 001.
- Unmodified elements in result retain their previous values only mid-operation. After DONE, every element reflects the current operation.

Test Plan:
- Add (defaults):
  - Stimulus: op1={1,2,3,4,5,6}, op2={10,20,30,40,50,60}, aluControl=000, saturate=0, resultReady=1.
  - Required: result={11,22,33,44,55,66}; resultValid rises exactly 3 cycles after accept; zeroMask=0; busy high for 3 cycles.
- Saturate vs wrap:
  - Stimulus: op1 all 200, op2 all 100, add.
  - Required: with saturate=0, all elements 44; with saturate=1, all 255.
  - Stimulus: op1 all 0, op2 all 1, sub.
  - Required: with saturate=0, all 0xFF and zeroMask=000000; with saturate=1, all 0x00 and zeroMask=111111.
- Scalar broadcast:
  - Stimulus: useScalar=1, scalarOperand=3, op1={1,2,3,4,5,90}, mul.
  - Required: result={3,6,9,12,15,14} (270 mod 256).
  - Stimulus: shl with scalar 9.
  - Required: shift by 1.
- Backpressure and back-to-back:
  - Stimulus: hold resultReady=0 for 5 cycles after DONE.
  - Required: result stable, startReady=0, busy=1.
  - Stimulus: then assert resultReady=1 together with startValid=1.
  - Required: old result consumed, new operation accepted that cycle, new resultValid 3 cycles later.
- Lane configurations:
  - LANES=4: 2-cycle latency, correct 6 elements, no out-of-range writes.
  - LANES=6: 1-cycle latency.
  - LANES=1: 6-cycle latency.
- Reset mid-operation:
  - Stimulus: drive reset=0 during pass 1.
  - Required: next edge state IDLE, resultValid=0, result=0, zeroMask=0, startReady=1; a subsequent operation completes normally.
